// File: rtl/pdp11_mem_arbiter_pkg.sv
// Shared types for the PDP-11 memory arbiter: bus widths, access kinds and arbiter state.
package common_pkg;
  typedef logic [15:0] mem_addr_t;
  typedef logic [7:0]  mem_data_t;
  typedef logic [15:0] word_t;

  typedef enum logic {SZ_WORD, SZ_BYTE}        op_size;
  typedef enum logic {DATA_READ, DATA_WRITE}   mem_access_t;
  typedef enum logic [1:0] {ARB_IDLE, ARB_LO, ARB_HI, ARB_FIN} arb_state_t;
  typedef enum logic {SRC_IF, SRC_OP}          arb_src_t;

  typedef struct packed {
    arb_src_t    src;
    mem_access_t acc;
    op_size      sz;
    mem_addr_t   addr;
    word_t       wdata;
  } arb_req_t;

  localparam int STREAK_W = 4;
endpackage

// File: rtl/pdp11_mem_arbiter_pick.sv
// Grant selection between IF and OP, with a saturating streak counter that bounds IF starvation.
module pdp11_arb_pick
  import common_pkg::*;
#(
  parameter int MAX_OP_STREAK = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     if_req_i,
  input  logic     op_req_i,
  input  logic     idle_i,
  output arb_src_t gnt_o
);
  logic [STREAK_W-1:0] streak_q, streak_d;

  always_comb begin
    gnt_o    = (op_req_i && !(if_req_i && streak_q == STREAK_W'(MAX_OP_STREAK))) ? SRC_OP : SRC_IF;
    streak_d = streak_q;
    if (idle_i) begin
      if (!if_req_i || gnt_o == SRC_IF)
        streak_d = '0;
      else if (streak_q != '1)
        streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) streak_q <= '0;
    else        streak_q <= streak_d;
  end
endmodule

// File: rtl/pdp11_mem_arbiter.sv
// Shares a byte-wide memory between IF and OP ports; words are two little-endian byte cycles.
// Define PDP_ODD_ADDR_TRAP_EN to trap odd-address word accesses instead of performing them.
module pdp11_mem_arbiter
  import common_pkg::*;
#(
  parameter int MAX_OP_STREAK = 4,
  parameter int RD_LAT        = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_done,
  output logic [15:0] if_rdata,
  output logic        if_err,
  input  logic        op_req,
  input  logic        op_we,
  input  logic        op_byte,
  input  logic [15:0] op_addr,
  input  logic [15:0] op_wdata,
  output logic        op_done,
  output logic [15:0] op_rdata,
  output logic        op_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);
  if (RD_LAT != 1) begin : g_rd_lat_chk
    $error("pdp11_mem_arbiter: only RD_LAT=1 is supported");
  end

  arb_state_t state_q;
  arb_req_t   req_q, req_d;
  arb_src_t   gnt;
  mem_data_t  lo_q;
  logic       mem_en_q, mem_we_q, if_done_q, op_done_q, trap_d;
  mem_addr_t  mem_addr_q;
  mem_data_t  mem_wdata_q;
  word_t      rdata;

  pdp11_arb_pick #(.MAX_OP_STREAK(MAX_OP_STREAK)) u_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .if_req_i(if_req),
    .op_req_i(op_req),
    .idle_i  (state_q == ARB_IDLE),
    .gnt_o   (gnt)
  );

  always_comb begin
    req_d = '0;
    if (gnt == SRC_IF) begin
      req_d.src  = SRC_IF;
      req_d.acc  = DATA_READ;
      req_d.sz   = SZ_WORD;
      req_d.addr = if_addr;
    end else begin
      req_d.src   = SRC_OP;
      req_d.acc   = op_we ? DATA_WRITE : DATA_READ;
      req_d.sz    = op_byte ? SZ_BYTE : SZ_WORD;
      req_d.addr  = op_addr;
      req_d.wdata = op_wdata;
    end
  end

`ifdef PDP_ODD_ADDR_TRAP_EN
  logic err_q;
  assign trap_d = (req_d.sz == SZ_WORD) && req_d.addr[0];
`else
  assign trap_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      req_q       <= '0;
      lo_q        <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      op_done_q   <= 1'b0;
`ifdef PDP_ODD_ADDR_TRAP_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if_done_q <= 1'b0;
          op_done_q <= 1'b0;
          if (if_req || op_req) begin
            req_q <= req_d;
            if (trap_d) begin
              // Trapped word: no memory cycle, complete with error next cycle.
              state_q   <= ARB_FIN;
              if_done_q <= (req_d.src == SRC_IF);
              op_done_q <= (req_d.src == SRC_OP);
`ifdef PDP_ODD_ADDR_TRAP_EN
              err_q     <= 1'b1;
`endif
            end else begin
              state_q     <= ARB_LO;
              mem_en_q    <= 1'b1;
              mem_we_q    <= (req_d.acc == DATA_WRITE);
              mem_addr_q  <= req_d.addr;
              mem_wdata_q <= req_d.wdata[7:0];
            end
          end
        end
        ARB_LO: begin
          if (req_q.sz == SZ_WORD) begin
            state_q     <= ARB_HI;
            mem_addr_q  <= req_q.addr + 16'd1;
            mem_wdata_q <= req_q.wdata[15:8];
          end else begin
            state_q     <= ARB_FIN;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= (req_q.src == SRC_IF);
            op_done_q   <= (req_q.src == SRC_OP);
          end
        end
        ARB_HI: begin
          // Low byte of the LO strobe arrives now; high byte arrives in FIN.
          lo_q        <= mem_rdata;
          state_q     <= ARB_FIN;
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          if_done_q   <= (req_q.src == SRC_IF);
          op_done_q   <= (req_q.src == SRC_OP);
        end
        ARB_FIN: begin
          state_q   <= ARB_IDLE;
          if_done_q <= 1'b0;
          op_done_q <= 1'b0;
`ifdef PDP_ODD_ADDR_TRAP_EN
          err_q     <= 1'b0;
`endif
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (state_q == ARB_FIN)
      rdata = (req_q.sz == SZ_WORD) ? {mem_rdata, lo_q} : {8'h00, mem_rdata};
`ifdef PDP_ODD_ADDR_TRAP_EN
    if (err_q) rdata = '0;
`endif
  end

  assign if_done   = if_done_q;
  assign op_done   = op_done_q;
  assign if_rdata  = if_done_q ? rdata : '0;
  assign op_rdata  = op_done_q ? rdata : '0;
`ifdef PDP_ODD_ADDR_TRAP_EN
  assign if_err    = if_done_q && err_q;
  assign op_err    = op_done_q && err_q;
`else
  assign if_err    = 1'b0;
  assign op_err    = 1'b0;
`endif
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != ARB_IDLE);
endmodule
